cache_fill_ctrl: RTL and testbench
==================================

Name: cache_fill_ctrl

Overview:
- Sequences a cache-block fill on a read or write miss: issues the block's word reads to fixed-latency main memory, then writes the returned words into the data array.
- Then writes the tag and sets the valid bit for the 7-bit set index; the index drives the 7-to-128 one-hot set decoder.
- Sits between the cache hit/miss logic and the shared memory port. One fill in flight at a time.

Parameters:
- MEM_LAT, 4, cycles from mem_rd assertion to matching mem_rdata valid (1..8)
- WORDS, 8, 16-bit words per block (power of 2, fixed with 16-bit address split below)
- IDX_W, 7, set index width (128 sets)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- miss_req  in  1  cache miss; held by cache until fill_done
- miss_addr  in  16  byte address of missing access; tag=[15:11], idx=[10:4], word=[3:1]
- mem_rd  out  1  memory read strobe, one word per cycle
- mem_addr  out  16  word-aligned read address
- mem_rdata  in  16  read data, valid exactly MEM_LAT cycles after its mem_rd
- data_we  out  1  data-array word write enable
- data_word  out  3  word offset within block being written
- data_wdata  out  16  word to write (registered mem_rdata path not required; pass-through)
- set_idx  out  7  set index for decoder; held stable for whole fill
- tag_we  out  1  tag/valid write strobe
- tag_wdata  out  5  tag to write
- valid_set  out  1  set valid bit of set_idx (asserted with tag_we)
- busy  out  1  fill in progress
- fill_done  out  1  one-cycle pulse, fill complete
- cw_ready  out  1  critical word written (optional feature; else tied 0)

Behaviour:
- Reset: every output 0; FSM IDLE; issue/receive counters 0; MEM_LAT-deep return-valid pipe cleared.
- States: IDLE, ISSUE, DRAIN, COMMIT.
- IDLE: miss_req sampled here only. When miss_req=1, latch miss_addr (tag, idx, word), set busy next cycle, and go to ISSUE with issue_cnt=0.
- ISSUE: mem_rd=1 and mem_addr={tag,idx,issue_cnt,1'b0} every cycle, then issue_cnt++. After the WORDS-th issue, go to DRAIN. WORDS back-to-back reads with no bubbles.
- Return pipe: each mem_rd pushes a 1 into a MEM_LAT-stage shift register. When the output stage is 1:
  - data_we=1, data_word=rcv_cnt, data_wdata=mem_rdata (same cycle), then rcv_cnt++.
  - A return may coincide with an ISSUE cycle when MEM_LAT<WORDS; both proceed.
- DRAIN: wait until the last word is written (rcv_cnt wraps to 0 after the WORDS-th write), then go to COMMIT.
- COMMIT: one cycle with tag_we=1, valid_set=1, tag_wdata=latched tag, fill_done=1. Next state IDLE; busy drops the following cycle.
- Timing, miss_req seen in IDLE at cycle t:
  - mem_rd on t+1..t+WORDS
  - writes on t+1+MEM_LAT..t+WORDS+MEM_LAT
  - COMMIT at t+WORDS+MEM_LAT+1 (=t+13 with defaults)
- miss_req dropping mid-fill is ignored; the fill completes.
- If miss_req is still high in the cycle after COMMIT, a new fill starts. Dropping it is the cache's responsibility.
- miss_addr changes after the IDLE sample are ignored.
- set_idx and tag_wdata are held from the latch until the next latch, and are 0 after reset.
- rst mid-fill: immediate return to IDLE; in-flight returns discarded; no data_we, tag_we or valid_set after the reset cycle; the partially written block stays invalid.

Optional Feature:
- Macro CRITICAL_WORD_FIRST_EN.
- Defined:
  - issue_cnt starts at the latched word offset and wraps mod WORDS; mem_addr and data_word follow the same wrapped order.
  - cw_ready pulses for one cycle with the first data_we, i.e. when the missing word is written.
  - COMMIT timing is unchanged.
- Undefined: order is 0..WORDS-1 and cw_ready is constant 0.

Test Plan:
- Reset, then idle 5 cycles with miss_req=0 -> all outputs 0, no mem_rd.
- miss_addr=0x1234 held, mem returns 0xA000+word:
  - mem_rd t+1..t+8, addresses 0x1230,0x1232..0x123E
  - data_we t+5..t+12 with words 0..7 and data 0xA000..0xA007
  - t+13: tag_we=1, tag_wdata=2, set_idx=0x23, valid_set=1, fill_done=1
- Two back-to-back misses (0x1234 then 0xFFF0, miss_req high through first fill_done) -> second fill mem_rd starts at commit+2; set_idx=0x7F, tag_wdata=0x1F.
- rst asserted at t+7 of a fill -> from t+8: no data_we, tag_we, valid_set or fill_done; busy=0; a new miss at t+10 completes normally 13 cycles later.
- MEM_LAT=1 build, miss_addr=0x0000 -> each return overlaps the next issue; commit at t+10, set_idx=0.
- CRITICAL_WORD_FIRST_EN, miss_addr=0x1234 -> mem_addr sequence 0x1234,0x1236..0x123E,0x1230,0x1232; cw_ready=1 at t+5 only, with data_word=2.

Source files
------------

// File: rtl/cache_fill_if.sv
// Fill-controller bus bundle: miss request, memory read port, data/tag array writes.
// master = cache/memory side, slave = fill controller.
interface cache_fill_if;
  logic        miss_req;
  logic [15:0] miss_addr;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        data_we;
  logic [2:0]  data_word;
  logic [15:0] data_wdata;
  logic [6:0]  set_idx;
  logic        tag_we;
  logic [4:0]  tag_wdata;
  logic        valid_set;
  logic        busy;
  logic        fill_done;
  logic        cw_ready;

  modport master (
    output miss_req, miss_addr, mem_rdata,
    input  mem_rd, mem_addr, data_we, data_word, data_wdata,
    input  set_idx, tag_we, tag_wdata, valid_set, busy,
    input  fill_done, cw_ready
  );

  modport slave (
    input  miss_req, miss_addr, mem_rdata,
    output mem_rd, mem_addr, data_we, data_word, data_wdata,
    output set_idx, tag_we, tag_wdata, valid_set, busy,
    output fill_done, cw_ready
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Cache block fill sequencer: issue word reads, write returns, commit tag/valid.
// Optional macro CRITICAL_WORD_FIRST_EN: wrap fill order to start at missing word.
module cache_fill_ctrl #(
  parameter int MEM_LAT = 4,
  parameter int WORDS   = 8,
  parameter int IDX_W   = 7
) (
  input logic        clk,
  input logic        rst,
  cache_fill_if.slave bus
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int TAG_W = 16 - IDX_W - OFF_W - 1;
  localparam logic [OFF_W-1:0] LAST = OFF_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, COMMIT} state_t;

  state_t             state_q, state_d;
  logic [OFF_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [OFF_W-1:0]   rcv_cnt_q, rcv_cnt_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [MEM_LAT-1:0] pipe_q, pipe_d;
  logic [OFF_W-1:0]   base;
  logic               ret;

`ifdef CRITICAL_WORD_FIRST_EN
  logic [OFF_W-1:0] off_q, off_d;
  logic unused_addr;

  assign base        = off_q;
  assign unused_addr = bus.miss_addr[0];

  // Latched critical-word offset; rotates both issue and write order.
  always_ff @(posedge clk) begin
    if (rst) off_q <= '0;
    else     off_q <= off_d;
  end

  // Capture offset only when a miss is accepted.
  always_comb begin
    off_d = off_q;
    if (state_q == IDLE && bus.miss_req)
      off_d = bus.miss_addr[OFF_W:1];
  end

  assign bus.cw_ready = ret && (rcv_cnt_q == '0);
`else
  logic unused_addr;

  assign base         = '0;
  assign unused_addr  = ^bus.miss_addr[OFF_W:0];
  assign bus.cw_ready = 1'b0;
`endif

  assign ret = pipe_q[MEM_LAT-1];

  // State, counters, latched address fields and return-valid pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      rcv_cnt_q   <= '0;
      tag_q       <= '0;
      idx_q       <= '0;
      pipe_q      <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      rcv_cnt_q   <= rcv_cnt_d;
      tag_q       <= tag_d;
      idx_q       <= idx_d;
      pipe_q      <= pipe_d;
    end
  end

  // Next state, return tracking and all bus outputs.
  always_comb begin
    state_d        = state_q;
    issue_cnt_d    = issue_cnt_q;
    rcv_cnt_d      = rcv_cnt_q;
    tag_d          = tag_q;
    idx_d          = idx_q;
    pipe_d         = '0;
    bus.mem_rd     = 1'b0;
    bus.mem_addr   = '0;
    bus.data_we    = 1'b0;
    bus.data_word  = '0;
    bus.data_wdata = '0;
    bus.tag_we     = 1'b0;
    bus.valid_set  = 1'b0;
    bus.fill_done  = 1'b0;
    bus.busy       = (state_q != IDLE);
    bus.set_idx    = idx_q;
    bus.tag_wdata  = tag_q;

    unique case (state_q)
      IDLE: begin
        if (bus.miss_req) begin
          tag_d       = bus.miss_addr[15 -: TAG_W];
          idx_d       = bus.miss_addr[OFF_W+1 +: IDX_W];
          issue_cnt_d = '0;
          rcv_cnt_d   = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = {tag_q, idx_q, issue_cnt_q + base, 1'b0};
        issue_cnt_d  = issue_cnt_q + 1'b1;
        if (issue_cnt_q == LAST) state_d = DRAIN;
      end
      DRAIN: begin
        if (ret && rcv_cnt_q == LAST) state_d = COMMIT;
      end
      COMMIT: begin
        bus.tag_we    = 1'b1;
        bus.valid_set = 1'b1;
        bus.fill_done = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Returns may land during ISSUE as well as DRAIN.
    if (ret) begin
      bus.data_we    = 1'b1;
      bus.data_word  = rcv_cnt_q + base;
      bus.data_wdata = bus.mem_rdata;
      rcv_cnt_d      = rcv_cnt_q + 1'b1;
    end

    pipe_d[0] = bus.mem_rd;
    for (int i = 1; i < MEM_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: MEM_LAT=4 and MEM_LAT=1 instances.
// Memory returns 16'hA000 + word offset of the address read.
module tb_cache_fill_ctrl;
  localparam int LA = 4;
`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cache_fill_if ifa ();
  cache_fill_if ifb ();

  cache_fill_ctrl #(.MEM_LAT(LA)) u_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  cache_fill_ctrl #(.MEM_LAT(1)) u_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  logic [15:0] pa [8];
  logic [15:0] pb;

  always @(posedge clk) begin
    for (int i = 7; i > 0; i--) pa[i] <= pa[i-1];
    pa[0] <= ifa.mem_addr;
    pb    <= ifb.mem_addr;
  end

  assign ifa.mem_rdata = 16'hA000 | {13'b0, pa[LA-1][3:1]};
  assign ifb.mem_rdata = 16'hA000 | {13'b0, pb[3:1]};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_a(input string tag);
    chk({tag, ".busy"}, 32'(ifa.busy), 0);
    chk({tag, ".mem_rd"}, 32'(ifa.mem_rd), 0);
    chk({tag, ".mem_addr"}, 32'(ifa.mem_addr), 0);
    chk({tag, ".data_we"}, 32'(ifa.data_we), 0);
    chk({tag, ".tag_we"}, 32'(ifa.tag_we), 0);
    chk({tag, ".valid_set"}, 32'(ifa.valid_set), 0);
    chk({tag, ".fill_done"}, 32'(ifa.fill_done), 0);
    chk({tag, ".cw_ready"}, 32'(ifa.cw_ready), 0);
  endtask

  // Called at the negedge of cycle t (miss_req already high).
  task automatic fill_a(input logic [15:0] a, input int drop_k);
    logic [4:0] tg;
    logic [6:0] ix;
    logic [2:0] off;
    logic [2:0] w;
    bit rd_e, we_e, cm_e;
    tg  = a[15:11];
    ix  = a[10:4];
    off = CWF ? a[3:1] : 3'd0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      rd_e = (k <= 8);
      we_e = (k >= LA + 1) && (k <= 8 + LA);
      cm_e = (k == 9 + LA);
      chk("mem_rd", 32'(ifa.mem_rd), 32'(rd_e));
      if (rd_e) begin
        w = 3'(32'(off) + k - 1);
        chk("mem_addr", 32'(ifa.mem_addr), 32'({tg, ix, w, 1'b0}));
      end
      chk("data_we", 32'(ifa.data_we), 32'(we_e));
      if (we_e) begin
        w = 3'(32'(off) + k - 1 - LA);
        chk("data_word", 32'(ifa.data_word), 32'(w));
        chk("data_wdata", 32'(ifa.data_wdata), 32'h0000A000 + 32'(w));
      end
      chk("cw_ready", 32'(ifa.cw_ready), 32'(CWF && k == LA + 1));
      chk("fill_done", 32'(ifa.fill_done), 32'(cm_e));
      chk("tag_we", 32'(ifa.tag_we), 32'(cm_e));
      chk("valid_set", 32'(ifa.valid_set), 32'(cm_e));
      chk("busy", 32'(ifa.busy), 1);
      chk("set_idx", 32'(ifa.set_idx), 32'(ix));
      chk("tag_wdata", 32'(ifa.tag_wdata), 32'(tg));
      if (k == drop_k) begin
        ifa.miss_req  = 1'b0;
        ifa.miss_addr = 16'h0BAD;
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    ifa.miss_req  = 1'b0;
    ifa.miss_addr = 16'h0;
    ifb.miss_req  = 1'b0;
    ifb.miss_addr = 16'h0;
    repeat (3) @(negedge clk);
    idle_a("rst");
    chk("rst.set_idx", 32'(ifa.set_idx), 0);
    chk("rst.tag_wdata", 32'(ifa.tag_wdata), 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle_a("idle");
    end

    ifa.miss_addr = 16'h1234;
    ifa.miss_req  = 1'b1;
    fill_a(16'h1234, 13);
    @(negedge clk);
    idle_a("post1");
    chk("post1.set_idx", 32'(ifa.set_idx), 32'h23);
    chk("post1.tag", 32'(ifa.tag_wdata), 2);
    repeat (2) @(negedge clk);

    ifa.miss_addr = 16'h1234;
    ifa.miss_req  = 1'b1;
    fill_a(16'h1234, 99);
    ifa.miss_addr = 16'hFFF0;
    @(negedge clk);
    chk("b2b.busy", 32'(ifa.busy), 0);
    chk("b2b.mem_rd", 32'(ifa.mem_rd), 0);
    fill_a(16'hFFF0, 2);
    @(negedge clk);
    idle_a("post2");
    chk("post2.set_idx", 32'(ifa.set_idx), 32'h7F);
    chk("post2.tag", 32'(ifa.tag_wdata), 32'h1F);

    @(negedge clk);
    ifa.miss_addr = 16'h1234;
    ifa.miss_req  = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("pre_rst.mem_rd", 32'(ifa.mem_rd), 1);
    end
    rst          = 1'b1;
    ifa.miss_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle_a("rst8");
    chk("rst8.set_idx", 32'(ifa.set_idx), 0);
    @(negedge clk);
    idle_a("rst9");
    @(negedge clk);
    idle_a("rst10");
    ifa.miss_addr = 16'hABCE;
    ifa.miss_req  = 1'b1;
    fill_a(16'hABCE, 1);
    @(negedge clk);
    idle_a("post3");

    @(negedge clk);
    ifb.miss_addr = 16'h0000;
    ifb.miss_req  = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      ifb.miss_req = 1'b0;
      chk("b.mem_rd", 32'(ifb.mem_rd), 32'(k <= 8));
      if (k <= 8) chk("b.mem_addr", 32'(ifb.mem_addr), 32'(2 * (k - 1)));
      chk("b.data_we", 32'(ifb.data_we), 32'(k >= 2 && k <= 9));
      if (k >= 2 && k <= 9) begin
        chk("b.data_word", 32'(ifb.data_word), 32'(k - 2));
        chk("b.data_wdata", 32'(ifb.data_wdata), 32'h0000A000 + 32'(k - 2));
      end
      chk("b.fill_done", 32'(ifb.fill_done), 32'(k == 10));
      chk("b.valid_set", 32'(ifb.valid_set), 32'(k == 10));
      chk("b.set_idx", 32'(ifb.set_idx), 0);
    end
    @(negedge clk);
    chk("b.busy_end", 32'(ifb.busy), 0);
    chk("b.done_end", 32'(ifb.fill_done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
